// File: rtl/demux_1x4_32bit_fifo.sv
// 1-to-4 demultiplexer with a DEPTH-entry FIFO on each output channel.
// One word per cycle is steered by in_select into its channel FIFO;
// each channel drains independently through its own valid/ready pair.

// Single output channel: a DEPTH-entry circular buffer.
module demux_1x4_32bit_fifo_chan #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         vld,
    output logic [W-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;

    // Status comes only from registered state, so there is no in->out path.
    assign full  = (count == (AW+1)'(DEPTH));
    assign vld   = (count != '0);
    assign rdata = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears storage too so the
    // head reads as zero afterwards. Pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: routes the input word to one of four channel FIFOs.
module demux_1x4_32bit_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_select,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] out3,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready,
    output logic        busy
);
    localparam int NUM_CH = 4;
    localparam int W      = 32;

    typedef struct packed {
        logic         vld;
        logic [1:0]   sel;
        logic [W-1:0] data;
    } in_req_t;

    in_req_t                      req;
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            push;
    logic [NUM_CH-1:0]            pop;
    logic [NUM_CH-1:0][W-1:0]     rdata;

    assign req = '{vld: in_valid, sel: in_select, data: in_data};

    // A full channel refuses the word even if it pops this cycle.
    assign in_ready = ~full[req.sel];

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            assign push[k] = req.vld && (req.sel == 2'(k)) && !full[k];
            assign pop[k]  = out_valid[k] && out_ready[k];

            demux_1x4_32bit_fifo_chan #(.DEPTH(DEPTH), .W(W)) u_chan (
                .clk     (clk),
                .reset_n (reset_n),
                .push    (push[k]),
                .pop     (pop[k]),
                .wdata   (req.data),
                .full    (full[k]),
                .vld     (out_valid[k]),
                .rdata   (rdata[k])
            );
        end
    endgenerate

    assign out0 = rdata[0];
    assign out1 = rdata[1];
    assign out2 = rdata[2];
    assign out3 = rdata[3];
    assign busy = |out_valid;
endmodule
